// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory arbiter.
// The state encoding, the NOP word returned on a timed-out transfer and
// the default bus widths live here so every arbiter file agrees on them.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  // addi x0, x0, 0 : what a stalled fetch sees when the memory never answers
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Memory wait watchdog for the unified arbiter (built only with ARB_TIMEOUT_EN).
// Counts BUSY cycles in which the memory has not answered; expire rises in the
// BUSY cycle that would bring the count to TIMEOUT, so the FSM can leave BUSY
// on that same edge.
module mem_arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic busy,
  input  logic m_ready,
  output logic expire
);

  localparam logic [7:0] LastCount = 8'(TIMEOUT - 1);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Clear on every new grant, count each unanswered BUSY cycle, never wrap
  always_comb begin
    count_d = count_q;
    if (start) begin
      count_d = 8'd0;
    end else if (busy && !m_ready && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  // Wait counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = busy & ~m_ready & (count_q == LastCount);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and the
// data stage. One requester is granted at a time; its address/data are
// registered onto the memory bus and a one-cycle ack with registered read
// data is returned once the memory reports ready.
// Optional feature: define ARB_TIMEOUT_EN to abandon transfers the memory
// never answers (ack with a NOP word plus an err pulse).
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic              err
);

  localparam logic [3:0]        MaxStreak = 4'(MAX_D_STREAK);
  localparam logic [DATA_W-1:0] NopWord   = DATA_W'(NOP_INSTR);

  arb_state_e        state_q;
  logic [3:0]        streak_q;
  logic [3:0]        streak_d;
  logic              i_ack_q;
  logic              d_ack_q;
  logic              err_q;
  logic              m_req_q;
  logic              m_we_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_wdata_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic iEligible;
  logic dEligible;
  logic grantI;
  logic grantD;
  logic expire;

  // A requester whose ack is high this cycle still shows its old req, so it is ignored
  assign iEligible = i_req & ~i_ack_q;
  assign dEligible = d_req & ~d_ack_q;

  // Data wins by default; fetch wins when alone or when data has used up its streak
  always_comb begin
    grantI   = 1'b0;
    grantD   = 1'b0;
    streak_d = streak_q;
    if (state_q == IDLE) begin
      if (dEligible && !(iEligible && (streak_q == MaxStreak))) begin
        grantD = 1'b1;
      end else if (iEligible) begin
        grantI = 1'b1;
      end
    end
    if (grantI) begin
      streak_d = 4'd0;
    end else if (grantD && iEligible && (streak_q != MaxStreak)) begin
      streak_d = streak_q + 4'd1;
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic wdStart;
  logic wdBusy;

  assign wdStart = grantI | grantD;
  assign wdBusy  = (state_q != IDLE);

  mem_arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) uWatchdog (
    .clk    (clk),
    .rst    (rst),
    .start  (wdStart),
    .busy   (wdBusy),
    .m_ready(m_ready),
    .expire (expire)
  );
`else
  // No watchdog in this build: the arbiter waits for the memory indefinitely
  assign expire = (TIMEOUT < 0);
`endif

  // Arbitration FSM with registered memory-side and requester-side outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      streak_q  <= 4'd0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      err_q     <= 1'b0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      i_ack_q  <= 1'b0;
      d_ack_q  <= 1'b0;
      err_q    <= 1'b0;
      streak_q <= streak_d;
      case (state_q)
        IDLE: begin
          if (grantD) begin
            m_addr_q  <= d_addr;
            m_we_q    <= d_we;
            m_wdata_q <= d_wdata;
            m_req_q   <= 1'b1;
            state_q   <= BUSY_D;
          end else if (grantI) begin
            m_addr_q <= i_addr;
            m_we_q   <= 1'b0;
            m_req_q  <= 1'b1;
            state_q  <= BUSY_I;
          end
        end
        BUSY_I: begin
          if (m_ready) begin
            i_rdata_q <= m_rdata;
            i_ack_q   <= 1'b1;
            m_req_q   <= 1'b0;
            state_q   <= IDLE;
          end else if (expire) begin
            i_rdata_q <= NopWord;
            i_ack_q   <= 1'b1;
            err_q     <= 1'b1;
            m_req_q   <= 1'b0;
            state_q   <= IDLE;
          end
        end
        BUSY_D: begin
          if (m_ready) begin
            if (!m_we_q) begin
              d_rdata_q <= m_rdata;
            end
            d_ack_q <= 1'b1;
            m_req_q <= 1'b0;
            m_we_q  <= 1'b0;
            state_q <= IDLE;
          end else if (expire) begin
            d_rdata_q <= NopWord;
            d_ack_q   <= 1'b1;
            err_q     <= 1'b1;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          m_req_q <= 1'b0;
          m_we_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign err     = err_q;
  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: reset, single fetch, contention,
// data-streak limit, memory wait states, asynchronous reset mid-transfer and,
// when ARB_TIMEOUT_EN is defined, the watchdog timeout.
// Inputs change #1 after a rising edge; outputs are checked at that point,
// so "cycle N" below means the cycle that starts at the N-th edge after the
// request was first presented.
module tb_unified_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready;
  logic        err;

  int checks = 0;
  int errors = 0;

  unified_mem_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .MAX_D_STREAK(2),
    .TIMEOUT     (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .i_req  (i_req),
    .i_addr (i_addr),
    .i_ack  (i_ack),
    .i_rdata(i_rdata),
    .d_req  (d_req),
    .d_we   (d_we),
    .d_addr (d_addr),
    .d_wdata(d_wdata),
    .d_ack  (d_ack),
    .d_rdata(d_rdata),
    .m_req  (m_req),
    .m_we   (m_we),
    .m_addr (m_addr),
    .m_wdata(m_wdata),
    .m_rdata(m_rdata),
    .m_ready(m_ready),
    .err    (err)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive every requester and memory input at once
  task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr,
                               input logic dReq, input logic dWe,
                               input logic [31:0] dAddr, input logic [31:0] dWdata,
                               input logic mReady, input logic [31:0] mRdata);
    i_req   = iReq;
    i_addr  = iAddr;
    d_req   = dReq;
    d_we    = dWe;
    d_addr  = dAddr;
    d_wdata = dWdata;
    m_ready = mReady;
    m_rdata = mRdata;
  endtask

  // One comparison: count it, and on a miss count and report it
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step();
    step();

    // ---------------- reset values ----------------
    checkOutput("rst_m_req", {31'd0, m_req}, 32'd0);
    checkOutput("rst_m_we", {31'd0, m_we}, 32'd0);
    checkOutput("rst_acks", {30'd0, i_ack, d_ack}, 32'd0);
    checkOutput("rst_m_addr", m_addr, 32'd0);
    checkOutput("rst_rdata", i_rdata | d_rdata, 32'd0);
    rst = 1'b0;
    step();

    // ---------------- single fetch, zero-wait memory ----------------
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0050_0093);
    checkOutput("fetch_c0_no_comb_req", {31'd0, m_req}, 32'd0);
    step();
    checkOutput("fetch_c1_m_req", {31'd0, m_req}, 32'd1);
    checkOutput("fetch_c1_m_addr", m_addr, 32'h40);
    checkOutput("fetch_c1_m_we", {31'd0, m_we}, 32'd0);
    step();
    checkOutput("fetch_c2_i_ack", {31'd0, i_ack}, 32'd1);
    checkOutput("fetch_c2_i_rdata", i_rdata, 32'h0050_0093);
    checkOutput("fetch_c2_m_req", {31'd0, m_req}, 32'd0);
    // i_req still high in the ack cycle is stale and must not start a transfer
    step();
    checkOutput("fetch_c3_stale_ignored", {31'd0, m_req}, 32'd0);
    checkOutput("fetch_c3_ack_pulse", {31'd0, i_ack}, 32'd0);
    checkOutput("fetch_c3_rdata_hold", i_rdata, 32'h0050_0093);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step();

    // ---------------- contention: data write first, fetch in d_ack cycle ----------------
    applyStimulus(1'b1, 32'h80, 1'b1, 1'b1, 32'h100, 32'hCAFE, 1'b1, 32'h1111_1111);
    step();
    checkOutput("cont_c1_m_addr", m_addr, 32'h100);
    checkOutput("cont_c1_m_we", {31'd0, m_we}, 32'd1);
    checkOutput("cont_c1_m_wdata", m_wdata, 32'hCAFE);
    step();
    checkOutput("cont_c2_d_ack", {31'd0, d_ack}, 32'd1);
    checkOutput("cont_c2_write_rdata_hold", d_rdata, 32'd0);
    m_rdata = 32'h2222_2222;
    step();
    d_req = 1'b0;
    checkOutput("cont_c3_fetch_granted", {31'd0, m_req}, 32'd1);
    checkOutput("cont_c3_m_addr", m_addr, 32'h80);
    checkOutput("cont_c3_m_we", {31'd0, m_we}, 32'd0);
    step();
    checkOutput("cont_c4_i_ack", {31'd0, i_ack}, 32'd1);
    checkOutput("cont_c4_i_rdata", i_rdata, 32'h2222_2222);
    i_req = 1'b0;
    step();

    // ---------------- data streak limit (MAX_D_STREAK = 2) ----------------
    // Fetch withdraws in each d_ack cycle (as on a redirect) so that data
    // competes against a live fetch request again without a fetch grant between.
    applyStimulus(1'b1, 32'h200, 1'b1, 1'b0, 32'h300, 32'h0, 1'b1, 32'hAAAA_0001);
    step();
    checkOutput("streak1_m_addr", m_addr, 32'h300);
    step();
    checkOutput("streak1_d_ack", {31'd0, d_ack}, 32'd1);
    checkOutput("streak1_d_rdata", d_rdata, 32'hAAAA_0001);
    i_req = 1'b0;
    step();
    checkOutput("streak1_idle", {31'd0, m_req}, 32'd0);
    applyStimulus(1'b1, 32'h200, 1'b1, 1'b0, 32'h304, 32'h0, 1'b1, 32'hAAAA_0002);
    step();
    checkOutput("streak2_data_wins", m_addr, 32'h304);
    step();
    checkOutput("streak2_d_rdata", d_rdata, 32'hAAAA_0002);
    i_req = 1'b0;
    step();
    applyStimulus(1'b1, 32'h200, 1'b1, 1'b0, 32'h308, 32'h0, 1'b1, 32'hBBBB_0003);
    step();
    checkOutput("streak_full_fetch_wins", m_addr, 32'h200);
    checkOutput("streak_full_m_we", {31'd0, m_we}, 32'd0);
    step();
    checkOutput("streak_full_i_ack", {31'd0, i_ack}, 32'd1);
    checkOutput("streak_full_i_rdata", i_rdata, 32'hBBBB_0003);
    i_req   = 1'b0;
    m_rdata = 32'hBBBB_0004;
    step();
    checkOutput("streak_after_data", m_addr, 32'h308);
    step();
    checkOutput("streak_after_d_ack", {31'd0, d_ack}, 32'd1);
    checkOutput("streak_after_d_rdata", d_rdata, 32'hBBBB_0004);
    d_req = 1'b0;
    step();

    // ---------------- three memory wait states ----------------
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h400, 32'h1234_5678, 1'b0, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      step();
      checkOutput("wait_m_req", {31'd0, m_req}, 32'd1);
      checkOutput("wait_m_addr", m_addr, 32'h400);
      checkOutput("wait_m_we", {31'd0, m_we}, 32'd1);
      checkOutput("wait_m_wdata", m_wdata, 32'h1234_5678);
      checkOutput("wait_no_ack", {31'd0, d_ack}, 32'd0);
      if (k == 4) m_ready = 1'b1;
    end
    step();
    checkOutput("wait_c5_d_ack", {31'd0, d_ack}, 32'd1);
    checkOutput("wait_err", {31'd0, err}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step();

    // ---------------- asynchronous reset in the middle of a read ----------------
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 32'h0, 1'b0, 32'h5555_5555);
    step();
    checkOutput("arst_busy", {31'd0, m_req}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_m_req_drops", {31'd0, m_req}, 32'd0);
    d_req = 1'b0;
    step();
    rst = 1'b0;
    checkOutput("arst_no_d_ack", {31'd0, d_ack}, 32'd0);
    checkOutput("arst_m_addr", m_addr, 32'd0);
    checkOutput("arst_rdata_cleared", i_rdata | d_rdata, 32'd0);
    step();
    checkOutput("arst_idle", {31'd0, m_req}, 32'd0);
    checkOutput("arst_still_no_ack", {31'd0, d_ack}, 32'd0);

`ifdef ARB_TIMEOUT_EN
    // ---------------- watchdog timeout, TIMEOUT = 8 ----------------
    applyStimulus(1'b1, 32'h600, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h7777_7777);
    for (int k = 1; k <= 8; k++) begin
      step();
      checkOutput("to_busy_m_req", {31'd0, m_req}, 32'd1);
      checkOutput("to_busy_no_ack", {31'd0, i_ack}, 32'd0);
    end
    step();
    checkOutput("to_i_ack", {31'd0, i_ack}, 32'd1);
    checkOutput("to_err", {31'd0, err}, 32'd1);
    checkOutput("to_nop", i_rdata, 32'h0000_0013);
    i_req = 1'b0;
    step();
    checkOutput("to_err_pulse", {31'd0, err}, 32'd0);

    // m_ready arriving in the would-be timeout cycle completes normally
    applyStimulus(1'b1, 32'h604, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h7777_7777);
    for (int k = 1; k <= 8; k++) begin
      step();
      checkOutput("to2_no_ack", {31'd0, i_ack}, 32'd0);
      if (k == 8) m_ready = 1'b1;
    end
    step();
    checkOutput("to2_i_ack", {31'd0, i_ack}, 32'd1);
    checkOutput("to2_err", {31'd0, err}, 32'd0);
    checkOutput("to2_rdata", i_rdata, 32'h7777_7777);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step();
`else
    // Without the watchdog err never rises, even after a long stall
    applyStimulus(1'b1, 32'h600, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h7777_7777);
    for (int k = 1; k <= 12; k++) begin
      step();
      checkOutput("nowd_m_req_held", {31'd0, m_req}, 32'd1);
      checkOutput("nowd_err", {31'd0, err}, 32'd0);
      checkOutput("nowd_no_ack", {31'd0, i_ack}, 32'd0);
    end
    m_ready = 1'b1;
    step();
    checkOutput("nowd_i_ack", {31'd0, i_ack}, 32'd1);
    checkOutput("nowd_rdata", i_rdata, 32'h7777_7777);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares one single-port unified memory between the fetch stage (instruction reads) and the memory stage (data reads/writes) of the 5-stage RV32I pipeline. It owns a small FSM that grants one requester at a time and registers the winner's address and data. It drives a req/ready transaction on the memory side and returns a one-cycle acknowledge with registered read data. The pipeline derives StallF and the memory-stage stall from `req & ~ack`.

## Interface
Parameters:
- ADDR_W, 32, address width, both requesters and memory.
- DATA_W, 32, data width.
- MAX_D_STREAK, 4, maximum consecutive data grants while fetch is waiting; 1..15.
- TIMEOUT, 255, memory wait limit in cycles; used only with `ARB_TIMEOUT_EN`; 1..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; **asynchronous, active-high**.
- i_req  in  1  fetch read request; held until i_ack.
- i_addr  in  ADDR_W  fetch address.
- i_ack  out  1  one-cycle pulse: fetch transfer complete.
- i_rdata  out  DATA_W  instruction word; valid while i_ack=1.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_ack  out  1  one-cycle pulse: data transfer complete.
- d_rdata  out  DATA_W  load data; valid while d_ack=1.
- m_req  out  1  memory request.
- m_we  out  1  memory write enable.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_rdata  in  DATA_W  memory read data; sampled when m_ready=1.
- m_ready  in  1  memory completes the current transfer this cycle.
- err  out  1  one-cycle pulse with the ack of a timed-out transfer; constant 0 without `ARB_TIMEOUT_EN`.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.
- **Eligibility in IDLE:** a requester is eligible if its req=1 and its ack is not high this cycle. A requester whose ack is high is ignored because its req is still stale.
- **Arbitration in IDLE:**
  - Data wins by default.
  - Fetch wins if only fetch is eligible.
  - Fetch also wins if both are eligible and streak == MAX_D_STREAK.
- **On grant:**
  - Latch addr, we (0 for fetch) and wdata into m_addr, m_we, m_wdata.
  - Next state is BUSY_I or BUSY_D.
- **BUSY_x:**
  - m_req=1 and the memory outputs are held stable.
  - On m_ready=1: register m_rdata into x_rdata, pulse x_ack next cycle, return to IDLE.
- **Streak counter (4-bit):**
  - Increments on a data grant while fetch is eligible, saturating at MAX_D_STREAK.
  - Clears on any fetch grant.
  - Holds otherwise.
- Write transfers return d_ack. d_rdata is undefined-but-stable (holds its previous value).
- i_rdata and d_rdata hold their values between acks.

## Timing
- **Reset values:** state IDLE; i_ack, d_ack, m_req, m_we, err = 0; m_addr, m_wdata, i_rdata, d_rdata = 0; streak = 0.
- **Reset mid-transfer:** m_req drops immediately (asynchronous). The transfer is abandoned and no ack is issued.
- **Zero-wait memory** (m_ready=1 in the first BUSY cycle):
  - Cycle 0: req seen in IDLE.
  - Cycle 1: m_req=1, m_ready=1.
  - Cycle 2: ack=1, rdata valid.
  - Latency is 2 cycles; each extra memory wait cycle adds 1.
- **Throughput:** back-to-back same requester takes 3 cycles per transfer. In the ack cycle the other requester can be granted, so alternating requesters achieve one transfer per 2 cycles.
- m_ready while m_req=0 is ignored.
- Simultaneous eligible requests are resolved in a single cycle per the rules above. There is no combinational path from req to m_req.

## Configuration
- Macro **`ARB_TIMEOUT_EN`**.
- **Defined:**
  - An 8-bit wait counter clears on entry to BUSY_x and increments each BUSY cycle without m_ready.
  - When the count reaches TIMEOUT, the FSM returns to IDLE. The arbiter pulses x_ack with x_rdata = 32'h0000_0013 (NOP) and pulses err in the same cycle.
  - m_ready in the same cycle as the timeout takes priority: normal completion, err=0.
- **Undefined:** no counter; the arbiter waits indefinitely; err tied to 0.

## Structure
- **Package `mem_arb_pkg`:**
  - state enum {IDLE, BUSY_I, BUSY_D};
  - the NOP constant 32'h0000_0013;
  - the default ADDR_W/DATA_W constants.
- **Sub-module `mem_arb_watchdog`:**
  - Contains the timeout counter: inputs clk, rst, start, busy, m_ready; output expire.
  - Instantiated only under `ARB_TIMEOUT_EN`.

## Test plan
- **Reset:** rst=1 during BUSY_D with m_ready=0 → m_req=0 in the same cycle, no d_ack; after release the state is IDLE and all outputs are 0.
- **Single fetch:** i_req=1, i_addr=0x40, m_ready=1 immediately, m_rdata=0x00500093 → m_addr=0x40 in cycle 1, i_ack=1 with i_rdata=0x00500093 in cycle 2.
- **Contention:** i_req and d_req both held, d_we=1, d_addr=0x100, d_wdata=0xCAFE → data granted first (m_we=1, m_addr=0x100); fetch is granted in the d_ack cycle.
- **Starvation:** i_req held, d_req re-asserted every cycle, MAX_D_STREAK=4, zero-wait memory → exactly 4 d_ack pulses, then i_ack, then streak restarts.
- **Wait states:** m_ready delayed 3 cycles → m_addr/m_we stable throughout; ack arrives at cycle 5.
- **Timeout (`ARB_TIMEOUT_EN`, TIMEOUT=8):** m_ready never asserted → i_ack=1, err=1, i_rdata=0x00000013 after 8 BUSY cycles; repeat with m_ready=1 on the 8th cycle → err=0.
